energy_regulator: RTL and testbench

Saturating energy accumulator that sits downstream of the sleep controller. It consumes the controller's `en_inc` / `en_dec` requests, prescales them into energy steps, and holds the mimosa's energy level. It publishes the 2-bit `energy_indicator` that the sleep controller reads, closing the loop.

---
 rtl/energy_regulator.sv | 128 ++++++++++++
 tb/tb_energy_regulator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/energy_regulator.sv
// energy_regulator: saturating energy accumulator fed by the sleep controller.
// Prescales charge/drain requests into energy steps, holds the energy level,
// derives a 2-bit band indicator through a one-step-per-cycle state machine
// and pulses depleted/replenished when the level first reaches a rail.
// Optional feature macro: ENERGY_REGULATOR_HYSTERESIS_EN
//   defined   -> downward indicator moves need level < threshold - HYST
//   undefined -> downward indicator moves need level < threshold
module energy_regulator #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE   = 16,
    parameter int INC_STEP   = 2,
    parameter int DEC_STEP   = 1,
    parameter int INIT_LEVEL = 128,
    parameter int T_LOW      = 64,
    parameter int T_MID      = 128,
    parameter int T_HIGH     = 192,
    parameter int HYST       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_inc,
    input  logic             en_dec,
    output logic [WIDTH-1:0] energy_level,
    output logic [1:0]       energy_indicator,
    output logic             depleted,
    output logic             replenished
);

    // Indicator states; the encoding doubles as the published band code.
    localparam logic [1:0] ST_EXH       = 2'b00;
    localparam logic [1:0] ST_TIRED     = 2'b01;
    localparam logic [1:0] ST_NORMAL    = 2'b10;
    localparam logic [1:0] ST_ENERGETIC = 2'b11;

    // Band a level falls into, ignoring hysteresis.
    function automatic logic [1:0] bandOf(input int lvl);
        if (lvl < T_LOW)       return ST_EXH;
        else if (lvl < T_MID)  return ST_TIRED;
        else if (lvl < T_HIGH) return ST_NORMAL;
        else                   return ST_ENERGETIC;
    endfunction

    // Lower threshold of the band a state represents.
    function automatic int lowerThr(input logic [1:0] st);
        case (st)
            ST_TIRED:     return T_LOW;
            ST_NORMAL:    return T_MID;
            ST_ENERGETIC: return T_HIGH;
            default:      return 0;
        endcase
    endfunction

    localparam int               PCW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCW-1:0]   PC_LAST   = PCW'(PRESCALE - 1);
    localparam logic [WIDTH:0]   MAX_EXT   = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] MAX_LEVEL = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   INC_W     = (WIDTH + 1)'(INC_STEP);
    localparam logic [WIDTH:0]   DEC_W     = (WIDTH + 1)'(DEC_STEP);
    localparam logic [WIDTH-1:0] INIT_W    = WIDTH'(INIT_LEVEL);
    localparam logic [1:0]       INIT_BAND = bandOf(INIT_LEVEL);
`ifdef ENERGY_REGULATOR_HYSTERESIS_EN
    localparam int               HYST_EFF  = HYST;
`else
    localparam int               HYST_EFF  = 0;
`endif

    logic [PCW-1:0]   pc_q, pc_d;
    logic             tick;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH:0]   levelExt, sumInc;
    logic [1:0]       ind_q, ind_d, target;
    logic             depleted_q, depleted_d;
    logic             replenished_q, replenished_d;

    // Prescaler: free-running 0..PRESCALE-1 counter whose last count is the step tick.
    always_comb begin
        tick = (pc_q == PC_LAST);
        pc_d = tick ? '0 : pc_q + PCW'(1);
    end

    // Level step: saturating add/subtract on a tick, widened by one bit so neither rail wraps.
    always_comb begin
        levelExt = {1'b0, level_q};
        sumInc   = levelExt + INC_W;
        level_d  = level_q;
        if (tick && en_inc && !en_dec) begin
            level_d = (sumInc > MAX_EXT) ? MAX_LEVEL : sumInc[WIDTH-1:0];
        end else if (tick && en_dec && !en_inc) begin
            level_d = (levelExt < DEC_W) ? '0 : level_q - DEC_W[WIDTH-1:0];
        end
        depleted_d    = (level_d == '0) && (level_q != '0);
        replenished_d = (level_d == MAX_LEVEL) && (level_q != MAX_LEVEL);
    end

    // Indicator: move one band per cycle toward the level's band, downward only past the margin.
    always_comb begin
        target = bandOf(int'(level_q));
        ind_d  = ind_q;
        if (target > ind_q) begin
            ind_d = ind_q + 2'd1;
        end else if ((target < ind_q) && ((int'(level_q) + HYST_EFF) < lowerThr(ind_q))) begin
            ind_d = ind_q - 2'd1;
        end
    end

    // State registers with synchronous reset that also discards any pending tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= '0;
            level_q       <= INIT_W;
            ind_q         <= INIT_BAND;
            depleted_q    <= 1'b0;
            replenished_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            level_q       <= level_d;
            ind_q         <= ind_d;
            depleted_q    <= depleted_d;
            replenished_q <= replenished_d;
        end
    end

    assign energy_level     = level_q;
    assign energy_indicator = ind_q;
    assign depleted         = depleted_q;
    assign replenished      = replenished_q;

endmodule

// File: tb/tb_energy_regulator.sv
// tb_energy_regulator: directed plus randomized checks of energy_regulator
// against a behavioural model of the level/indicator/pulse rules.
module tb_energy_regulator;

    localparam int P    = 4;
    localparam int MAXL = 255;
`ifdef ENERGY_REGULATOR_HYSTERESIS_EN
    localparam int HYSTM = 8;
    localparam int TRIG  = 55;
`else
    localparam int HYSTM = 0;
    localparam int TRIG  = 63;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1, enInc = 1'b0, enDec = 1'b0;
    logic [7:0] energyLevel;
    logic [1:0] energyIndicator;
    logic       depleted, replenished;

    logic       rst2 = 1'b1, enInc2 = 1'b0, enDec2 = 1'b0;
    logic [7:0] energyLevel2;
    logic [1:0] energyIndicator2;
    logic       depleted2, replenished2;

    int errors = 0;
    int checks = 0;

    int mLevel = 0, mPc = 0, mInd = 0;
    bit mDep = 0, mRep = 0, modelValid = 0;

    always #5 clk = ~clk;

    energy_regulator #(.PRESCALE(P)) dut (
        .clk(clk), .rst(rst), .en_inc(enInc), .en_dec(enDec),
        .energy_level(energyLevel), .energy_indicator(energyIndicator),
        .depleted(depleted), .replenished(replenished)
    );

    energy_regulator #(.PRESCALE(1), .INC_STEP(200), .INIT_LEVEL(10)) dut2 (
        .clk(clk), .rst(rst2), .en_inc(enInc2), .en_dec(enDec2),
        .energy_level(energyLevel2), .energy_indicator(energyIndicator2),
        .depleted(depleted2), .replenished(replenished2)
    );

    function automatic int bandOf(input int lvl);
        if (lvl < 64)  return 0;
        if (lvl < 128) return 1;
        if (lvl < 192) return 2;
        return 3;
    endfunction

    function automatic int thrOf(input int band);
        return band * 64;
    endfunction

    // One clock of the reference behaviour, using values held before the edge.
    task automatic modelStep();
        int nl;
        int tgt;
        bit tk;
        if (rst) begin
            mLevel = 128; mPc = 0; mInd = bandOf(128);
            mDep = 0; mRep = 0; modelValid = 1;
        end else begin
            tk  = (mPc == P - 1);
            mPc = (mPc + 1) % P;
            nl  = mLevel;
            if (tk && enInc && !enDec) nl = (mLevel + 2 > MAXL) ? MAXL : mLevel + 2;
            else if (tk && enDec && !enInc) nl = (mLevel < 1) ? 0 : mLevel - 1;
            tgt = bandOf(mLevel);
            if (tgt > mInd) mInd = mInd + 1;
            else if (tgt < mInd && mLevel < thrOf(mInd) - HYSTM) mInd = mInd - 1;
            mDep   = (nl == 0) && (mLevel != 0);
            mRep   = (nl == MAXL) && (mLevel != MAXL);
            mLevel = nl;
        end
    endtask

    task automatic checkVal(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        if (modelValid) begin
            checkVal("level", int'(energyLevel), mLevel);
            checkVal("indicator", int'(energyIndicator), mInd);
            checkVal("depleted", int'(depleted), int'(mDep));
            checkVal("replenished", int'(replenished), int'(mRep));
        end
    endtask

    // Drive one cycle's inputs at the falling edge, model at the rising edge, check at the next falling edge.
    task automatic applyStimulus(input bit inc, input bit dec, input bit r);
        enInc = inc; enDec = dec; rst = r;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        int q[$];
        int lastLvl, repCount, depCount, pulseCount, lvlSeen, indZero;
        bit rIn, iIn, dIn;
        int hold;

        @(negedge clk);
        $display("[TB] reset");
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        checkVal("reset_level", int'(energyLevel), 128);
        checkVal("reset_indicator", int'(energyIndicator), 2);
        checkVal("reset_pulses", int'(depleted) + int'(replenished), 0);

        $display("[TB] first tick after release");
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0);
        checkVal("pre_tick_level", int'(energyLevel), 128);
        applyStimulus(1, 0, 0);
        checkVal("first_tick_level", int'(energyLevel), 130);

        $display("[TB] charge to saturation");
        for (int i = 0; i < 240; i++) applyStimulus(1, 0, 0);
        checkVal("level_250", int'(energyLevel), 250);
        lastLvl = 250; repCount = 0;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1, 0, 0);
            if (int'(energyLevel) != lastLvl) begin
                lastLvl = int'(energyLevel);
                q.push_back(lastLvl);
            end
            if (replenished) repCount++;
        end
        checkVal("charge_steps", q.size(), 3);
        if (q.size() == 3) begin
            checkVal("charge_step0", q[0], 252);
            checkVal("charge_step1", q[1], 254);
            checkVal("charge_step2", q[2], 255);
        end
        checkVal("replenished_count", repCount, 1);
        checkVal("full_indicator", int'(energyIndicator), 3);

        $display("[TB] drain to zero");
        for (int i = 0; i < 756; i++) applyStimulus(0, 1, 0);
        checkVal("level_66", int'(energyLevel), 66);
        checkVal("indicator_66", int'(energyIndicator), 1);
        lvlSeen = -1; indZero = -1; depCount = 0;
        for (int c = 0; c < 290; c++) begin
            applyStimulus(0, 1, 0);
            if (lvlSeen < 0 && int'(energyLevel) == TRIG) lvlSeen = c;
            if (indZero < 0 && energyIndicator == 2'b00) indZero = c;
            if (depleted) depCount++;
        end
        checkVal("exhausted_latency", indZero - lvlSeen, 1);
        checkVal("drained_level", int'(energyLevel), 0);
        checkVal("depleted_count", depCount, 1);

        $display("[TB] simultaneous requests");
        for (int i = 0; i < 200; i++) applyStimulus(1, 0, 0);
        checkVal("level_100", int'(energyLevel), 100);
        pulseCount = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1, 0);
            pulseCount += int'(depleted) + int'(replenished);
        end
        checkVal("both_level", int'(energyLevel), 100);
        checkVal("both_pulses", pulseCount, 0);

        $display("[TB] randomized traffic");
        hold = 0; iIn = 0; dIn = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                iIn  = 1'($urandom_range(0, 1));
                dIn  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 40);
            end
            hold--;
            rIn = ($urandom_range(0, 299) == 0);
            applyStimulus(iIn, dIn, rIn);
        end

        $display("[TB] multi-band jump");
        enInc2 = 0; rst2 = 1;
        @(posedge clk); @(negedge clk);
        rst2 = 0;
        checkVal("jump_init_level", int'(energyLevel2), 10);
        checkVal("jump_init_ind", int'(energyIndicator2), 0);
        enInc2 = 1;
        @(posedge clk); @(negedge clk);
        enInc2 = 0;
        checkVal("jump_level", int'(energyLevel2), 210);
        checkVal("jump_ind_0", int'(energyIndicator2), 0);
        checkVal("jump_pulses", int'(depleted2) + int'(replenished2), 0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); @(negedge clk);
            checkVal("jump_ind_step", int'(energyIndicator2), (k > 3) ? 3 : k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
